// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption round controller: sequences round keys and latches the
// external round datapath result once per cycle, then holds the ciphertext until accepted.
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inValid,
    output logic         inReady,
    input  logic [127:0] inData,
    output logic [3:0]   keyIndex,
    input  logic [127:0] roundKey,
    output logic [127:0] roundState,
    output logic         finalRound,
    input  logic [127:0] roundResult,
    input  logic         flush,
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] outData,
    output logic         busy
);

    localparam logic [3:0] LAST_CNT   = 4'(NUM_ROUNDS);
    localparam logic [3:0] PENULT_CNT = 4'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e         state_q,     state_d;
    logic [3:0]     round_cnt_q, round_cnt_d;
    logic [127:0]   state_reg_q, state_reg_d;

    // State register, round counter and AES state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            round_cnt_q <= 4'd0;
            state_reg_q <= 128'd0;
        end else begin
            state_q     <= state_d;
            round_cnt_q <= round_cnt_d;
            state_reg_q <= state_reg_d;
        end
    end

    // Next-state logic; flush has priority over every transition
    always_comb begin
        state_d     = state_q;
        round_cnt_d = round_cnt_q;
        state_reg_d = state_reg_q;
        if (flush) begin
            state_d     = ST_IDLE;
            round_cnt_d = 4'd0;
            state_reg_d = 128'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (inValid) begin
                        state_d     = ST_ROUND;
                        round_cnt_d = 4'd1;
                        state_reg_d = inData ^ roundKey;
                    end else begin
                        state_d     = ST_IDLE;
                    end
                end
                ST_ROUND: begin
                    state_reg_d = roundResult;
                    // Compare with >= so a corrupted count saturates instead of wrapping
                    if (round_cnt_q >= PENULT_CNT) begin
                        state_d     = ST_FINAL;
                        round_cnt_d = LAST_CNT;
                    end else begin
                        round_cnt_d = round_cnt_q + 4'd1;
                    end
                end
                ST_FINAL: begin
                    state_reg_d = roundResult;
                    round_cnt_d = LAST_CNT;
                    state_d     = ST_DONE;
                end
                ST_DONE: begin
                    if (outReady) begin
                        state_d     = ST_IDLE;
                        round_cnt_d = 4'd0;
                    end else begin
                        state_d     = ST_DONE;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    round_cnt_d = 4'd0;
                end
            endcase
        end
    end

    // Output decode from the current state
    always_comb begin
        keyIndex   = 4'd0;
        finalRound = 1'b0;
        outValid   = 1'b0;
        inReady    = 1'b0;
        busy       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                inReady = 1'b1;
                busy    = 1'b0;
            end
            ST_ROUND: begin
                keyIndex = round_cnt_q;
            end
            ST_FINAL: begin
                keyIndex   = round_cnt_q;
                finalRound = 1'b1;
            end
            ST_DONE: begin
                keyIndex = LAST_CNT;
                outValid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    assign roundState = state_reg_q;
    assign outData    = state_reg_q;

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Parameters
REQ-001 NUM_ROUNDS, default 10, total AES rounds; the only legal values are 10, 12 and 14 (AES-128/192/256).

Interface
REQ-002 clock  in  1  system clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 inValid  in  1  inData is valid.
REQ-005 inReady  out  1  controller can accept a block.
REQ-006 inData  in  128  plaintext block, byte 0 in [127:120].
REQ-007 keyIndex  out  4  round-key select to the external key store, range 0..NUM_ROUNDS.
REQ-008 roundKey  in  128  round key for keyIndex, combinational from the key store in the same cycle.
REQ-009 roundState  out  128  current state register, driven to the external round datapath.
REQ-010 finalRound  out  1  tells the datapath to skip MixColumns.
REQ-011 roundResult  in  128  combinational datapath output: SubBytes, ShiftRows, optional MixColumns, then AddRoundKey(roundKey).
REQ-012 flush  in  1  synchronous abort.
REQ-013 outValid  out  1  outData holds the ciphertext.
REQ-014 outReady  in  1  downstream accepts outData.
REQ-015 outData  out  128  ciphertext block, equal to the state register.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have four states: IDLE, ROUND, FINAL, DONE, plus a 4-bit roundCnt and a 128-bit stateReg.
REQ-018 inReady SHALL be 1 only in IDLE; blocks SHALL never overlap, and inValid outside IDLE SHALL be ignored.
REQ-019 Combinational outputs:
- In IDLE: keyIndex=0.
- In ROUND and FINAL: keyIndex=roundCnt.
- In DONE: keyIndex=NUM_ROUNDS.
- finalRound=1 only in FINAL.
- outValid=1 only in DONE.
REQ-020 Accept (IDLE, inValid=1): stateReg<=inData XOR roundKey (key 0), roundCnt<=1, next state ROUND.
REQ-021 ROUND: each edge stateReg<=roundResult and roundCnt<=roundCnt+1; when roundCnt==NUM_ROUNDS-1, next state FINAL.
REQ-022 FINAL: stateReg<=roundResult, next state DONE; roundCnt holds NUM_ROUNDS.
REQ-023 DONE: stateReg and outData SHALL hold stable while outReady=0; on outReady=1, next state IDLE and roundCnt<=0.
REQ-024 Latency: outValid SHALL rise exactly NUM_ROUNDS edges after the accepting edge.
- Minimum accept-to-accept spacing is NUM_ROUNDS+2 cycles with outReady held high.
REQ-025 flush=1 in any state SHALL force IDLE, roundCnt<=0 and stateReg<=0 on the next edge.
- flush overrides accept, round advance and the output handshake.
- A block offered in the same cycle SHALL NOT be accepted.
REQ-026 roundCnt SHALL never exceed NUM_ROUNDS and SHALL not wrap.
- An illegal FSM encoding SHALL recover to IDLE on the next edge.
REQ-027 stateReg SHALL update only on accept, ROUND, FINAL or flush; it is never partially written.

Reset
REQ-028 While reset=1, asynchronously and independent of clock, outputs SHALL be:
- FSM=IDLE, roundCnt=0, stateReg=0.
- outValid=0, finalRound=0, busy=0, keyIndex=0, outData=0, roundState=0, inReady=1.
REQ-029 Reset asserted mid-block SHALL discard that block with no outValid pulse; the first edge after deassertion SHALL be able to accept a block.

Verification
REQ-030 Bench connects the team's AES-128 round datapath and key store (key 2b7e151628aed2a6abf7158809cf4f3c). Scenarios:
- Nominal: inData=3243f6a8885a308d313198a2e0370734, outReady=1 -> outValid rises 10 edges after accept, outData=3925841d02dc09fbdc118597196a0b32, keyIndex sequence 0,1..10, finalRound high for exactly one cycle.
- Backpressure: outReady=0 for 5 cycles in DONE -> outValid and outData stable; IDLE one edge after outReady=1.
- Busy drop: inValid pulses while busy -> no effect; two back-to-back blocks accepted 12 cycles apart, both ciphertexts correct.
- Flush: flush in ROUND at roundCnt=5 -> next cycle IDLE, stateReg=0, no outValid; flush with inValid in IDLE -> block not accepted.
- Reset mid-block: async reset at roundCnt=7 (between edges) -> outputs at reset values immediately; a new block then completes correctly.
- Parameter: NUM_ROUNDS=14 with an AES-256 key store -> outValid 14 edges after accept; FIPS-197 C.3 vector matches.
